// File: rtl/extremum_autorange_ctrl.sv
// extremum_autorange_ctrl: arms finder windows, discards settling windows, autoranges EF_shift from p2p
// Optional watchdog (ST_timeout port) enabled by defining EXTREMUM_CTRL_WATCHDOG_EN.
module extremum_autorange_ctrl #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int SETTLE_WIDTH     = 4
) (
    input  logic                        SYS_aclk,
    input  logic                        SYS_aresetn,
    input  logic                        CFG_enable,
    input  logic [4:0]                  CFG_log_count,
    input  logic [2:0]                  CFG_shift_init,
    input  logic [AXIS_TDATA_WIDTH-1:0] CFG_hi_thresh,
    input  logic [AXIS_TDATA_WIDTH-1:0] CFG_lo_thresh,
    input  logic [SETTLE_WIDTH-1:0]     CFG_settle,
    input  logic [AXIS_TDATA_WIDTH-1:0] EF_min,
    input  logic [AXIS_TDATA_WIDTH-1:0] EF_max,
    input  logic                        EF_valid,
    output logic [4:0]                  EF_log_count,
    output logic [2:0]                  EF_shift,
    output logic [AXIS_TDATA_WIDTH-1:0] ST_p2p,
    output logic                        ST_valid,
    output logic                        ST_overrange,
    output logic                        ST_underrange,
    output logic                        ST_cfg_err,
    output logic                        ST_busy
`ifdef EXTREMUM_CTRL_WATCHDOG_EN
    ,
    output logic                        ST_timeout
`endif
);
    localparam int W = AXIS_TDATA_WIDTH;

    typedef enum logic [2:0] {IDLE, ARM, SETTLE, MEASURE, EVAL} state_t;

    state_t                  state_q, state_d;
    logic [4:0]              log_q, log_d;
    logic [2:0]              shift_q, shift_d;
    logic [SETTLE_WIDTH-1:0] settle_q, settle_d;
    logic [W-1:0]            p2p_q, p2p_d;
    logic                    over_q, over_d, under_q, under_d, err_q, err_d;
    logic [W:0]              diff;
    logic [W-1:0]            p2p;
    logic                    up, dn;
`ifdef EXTREMUM_CTRL_WATCHDOG_EN
    logic [35:0]             wd_q, wd_d, limit;
    logic                    to_q, to_d;
`endif

    // Sign-extended difference can only underflow; a negative result clamps to zero.
    always_comb begin
        diff = {EF_max[W-1], EF_max} - {EF_min[W-1], EF_min};
        p2p  = diff[W] ? '0 : diff[W-1:0];
        up   = (p2p_q > CFG_hi_thresh) && (shift_q != 3'd7) && (CFG_lo_thresh < CFG_hi_thresh);
        dn   = (p2p_q < CFG_lo_thresh) && (shift_q != 3'd0) && (CFG_lo_thresh < CFG_hi_thresh);
    end

    // Next-state sequencing; p2p and range flags are captured at window end so they appear with ST_valid.
    always_comb begin
        state_d  = state_q;
        log_d    = log_q;
        shift_d  = shift_q;
        settle_d = settle_q;
        p2p_d    = p2p_q;
        over_d   = over_q;
        under_d  = under_q;
        err_d    = CFG_enable && (state_q == IDLE) && (CFG_log_count == 5'd0);
        if (!CFG_enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (CFG_log_count != 5'd0) begin
                    state_d = ARM;
                    log_d   = CFG_log_count;
                    shift_d = CFG_shift_init;
                end
                ARM: begin
                    settle_d = CFG_settle;
                    state_d  = (CFG_settle != '0) ? SETTLE : MEASURE;
                end
                SETTLE: if (EF_valid) begin
                    settle_d = settle_q - SETTLE_WIDTH'(1);
                    state_d  = (settle_q == SETTLE_WIDTH'(1)) ? MEASURE : SETTLE;
                end
                MEASURE: if (EF_valid) begin
                    state_d = EVAL;
                    p2p_d   = p2p;
                    over_d  = (p2p > CFG_hi_thresh) && (shift_q == 3'd7);
                    under_d = (p2p < CFG_lo_thresh) && (shift_q == 3'd0);
                end
                EVAL: begin
                    shift_d = up ? shift_q + 3'd1 : dn ? shift_q - 3'd1 : shift_q;
                    state_d = (up || dn) ? ARM : MEASURE;
                end
                default: state_d = IDLE;
            endcase
        end
`ifdef EXTREMUM_CTRL_WATCHDOG_EN
        limit = 36'd1 << ({1'b0, log_q} + 6'd2);
        wd_d  = '0;
        to_d  = (state_q == IDLE) ? 1'b0 : to_q;
        if (CFG_enable && !EF_valid && (state_q == SETTLE || state_q == MEASURE)) begin
            if (wd_q + 36'd1 == limit) begin
                state_d = ARM;
                to_d    = 1'b1;
            end else begin
                wd_d = wd_q + 36'd1;
            end
        end
`endif
    end

    // State and status registers.
    always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
        if (!SYS_aresetn) begin
            state_q  <= IDLE;
            log_q    <= '0;
            shift_q  <= '0;
            settle_q <= '0;
            p2p_q    <= '0;
            over_q   <= 1'b0;
            under_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            log_q    <= log_d;
            shift_q  <= shift_d;
            settle_q <= settle_d;
            p2p_q    <= p2p_d;
            over_q   <= over_d;
            under_q  <= under_d;
            err_q    <= err_d;
        end
    end

`ifdef EXTREMUM_CTRL_WATCHDOG_EN
    // Watchdog cycle counter and sticky timeout flag.
    always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
        if (!SYS_aresetn) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end

    assign ST_timeout = to_q;
`endif

    assign EF_log_count  = (CFG_enable && state_q != IDLE && state_q != ARM) ? log_q : 5'd0;
    assign EF_shift      = shift_q;
    assign ST_p2p        = p2p_q;
    assign ST_valid      = (state_q == EVAL);
    assign ST_overrange  = over_q;
    assign ST_underrange = under_q;
    assign ST_cfg_err    = err_q;
    assign ST_busy       = (state_q != IDLE);
endmodule

// File: tb/tb_extremum_autorange_ctrl.sv
// tb_extremum_autorange_ctrl: directed self-checking bench for extremum_autorange_ctrl
module tb_extremum_autorange_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [4:0]  log_c = 5'd3;
    logic [2:0]  sh_init = 3'd2;
    logic [31:0] hi = 32'd100, lo = 32'd20;
    logic [3:0]  settle = 4'd1;
    logic [31:0] ef_min = '0, ef_max = '0;
    logic        ef_valid = 1'b0;
    logic [4:0]  ef_log;
    logic [2:0]  ef_shift;
    logic [31:0] p2p;
    logic        st_valid, over, under, cfg_err, busy;
`ifdef EXTREMUM_CTRL_WATCHDOG_EN
    logic        timeout;
`endif
    int checks = 0, errors = 0;

    extremum_autorange_ctrl #(.AXIS_TDATA_WIDTH(32), .SETTLE_WIDTH(4)) dut (
        .SYS_aclk(clk), .SYS_aresetn(rst_n), .CFG_enable(en), .CFG_log_count(log_c),
        .CFG_shift_init(sh_init), .CFG_hi_thresh(hi), .CFG_lo_thresh(lo), .CFG_settle(settle),
        .EF_min(ef_min), .EF_max(ef_max), .EF_valid(ef_valid), .EF_log_count(ef_log),
        .EF_shift(ef_shift), .ST_p2p(p2p), .ST_valid(st_valid), .ST_overrange(over),
        .ST_underrange(under), .ST_cfg_err(cfg_err), .ST_busy(busy)
`ifdef EXTREMUM_CTRL_WATCHDOG_EN
        , .ST_timeout(timeout)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [31:0] mn, input logic [31:0] mx);
        ef_min = mn;
        ef_max = mx;
        ef_valid = 1'b1;
        tick();
        ef_valid = 1'b0;
    endtask

    task automatic arm(input logic [2:0] s, input logic [3:0] st);
        en = 1'b0;
        tick();
        sh_init = s;
        settle = st;
        log_c = 5'd3;
        en = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pulse(-32'sd5, 32'sd70);
            checks++;
            if ({ef_log, ef_shift, p2p, st_valid, over, under, cfg_err, busy} !== '0) begin
                errors++;
                $display("FAIL reset: outputs=%h required 0", {ef_log, ef_shift, p2p, st_valid, over, under, cfg_err, busy});
            end
        end
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_discard_and_measure();
        log_c = 5'd3; sh_init = 3'd2; settle = 4'd1; hi = 32'd100; lo = 32'd20;
        en = 1'b1;
        tick();
        checks++;
        if (ef_log !== 5'd0 || !busy || ef_shift !== 3'd2) begin
            errors++;
            $display("FAIL arm: log=%0d busy=%0b shift=%0d required 0/1/2", ef_log, busy, ef_shift);
        end
        tick();
        checks++;
        if (ef_log !== 5'd3) begin
            errors++;
            $display("FAIL settle_log: got %0d required 3", ef_log);
        end
        pulse(-32'sd10, 32'sd40);
        checks++;
        if (st_valid !== 1'b0) begin
            errors++;
            $display("FAIL discard: st_valid=%0b required 0", st_valid);
        end
        tick(); tick();
        pulse(-32'sd10, 32'sd40);
        checks++;
        if (st_valid !== 1'b1 || p2p !== 32'd50) begin
            errors++;
            $display("FAIL measure: valid=%0b p2p=%0d required 1/50", st_valid, p2p);
        end
        tick();
        checks++;
        if (st_valid !== 1'b0 || ef_shift !== 3'd2 || ef_log !== 5'd3) begin
            errors++;
            $display("FAIL hold_shift: valid=%0b shift=%0d log=%0d required 0/2/3", st_valid, ef_shift, ef_log);
        end
    endtask

    task automatic test_shift_up();
        pulse(-32'sd60, 32'sd60);
        checks++;
        if (st_valid !== 1'b1 || p2p !== 32'd120) begin
            errors++;
            $display("FAIL up_p2p: valid=%0b p2p=%0d required 1/120", st_valid, p2p);
        end
        tick();
        checks++;
        if (ef_shift !== 3'd3 || ef_log !== 5'd0) begin
            errors++;
            $display("FAIL up_rearm: shift=%0d log=%0d required 3/0", ef_shift, ef_log);
        end
        tick();
        pulse(-32'sd1, 32'sd1);
        checks++;
        if (st_valid !== 1'b0 || p2p !== 32'd120) begin
            errors++;
            $display("FAIL up_discard: valid=%0b p2p=%0d required 0/120", st_valid, p2p);
        end
    endtask

    task automatic test_boundaries();
        arm(3'd3, 4'd0);
        pulse(32'sd0, 32'sd100);
        tick();
        checks++;
        if (ef_shift !== 3'd3 || ef_log !== 5'd3) begin
            errors++;
            $display("FAIL equal_hi: shift=%0d log=%0d required 3/3", ef_shift, ef_log);
        end
        pulse(32'sd50, -32'sd50);
        checks++;
        if (p2p !== 32'd0 || st_valid !== 1'b1) begin
            errors++;
            $display("FAIL neg_clamp: p2p=%0d valid=%0b required 0/1", p2p, st_valid);
        end
        tick();
        checks++;
        if (ef_shift !== 3'd2) begin
            errors++;
            $display("FAIL shift_down: got %0d required 2", ef_shift);
        end
        tick();
        pulse(32'h8000_0000, 32'h7FFF_FFFF);
        checks++;
        if (p2p !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL full_span: got %h required ffffffff", p2p);
        end
    endtask

    task automatic test_range_flags();
        arm(3'd7, 4'd0);
        pulse(32'sd0, 32'sd500);
        tick();
        checks++;
        if (over !== 1'b1 || under !== 1'b0 || ef_shift !== 3'd7 || p2p !== 32'd500) begin
            errors++;
            $display("FAIL overrange: over=%0b under=%0b shift=%0d p2p=%0d required 1/0/7/500", over, under, ef_shift, p2p);
        end
        arm(3'd0, 4'd0);
        pulse(32'sd100, 32'sd105);
        tick();
        checks++;
        if (under !== 1'b1 || over !== 1'b0 || ef_shift !== 3'd0 || p2p !== 32'd5) begin
            errors++;
            $display("FAIL underrange: under=%0b over=%0b shift=%0d p2p=%0d required 1/0/0/5", under, over, ef_shift, p2p);
        end
        en = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || under !== 1'b1 || p2p !== 32'd5) begin
            errors++;
            $display("FAIL retain: busy=%0b under=%0b p2p=%0d required 0/1/5", busy, under, p2p);
        end
    endtask

    task automatic test_cfg_err_and_abort();
        log_c = 5'd0;
        en = 1'b1;
        tick();
        checks++;
        if (cfg_err !== 1'b1 || ef_log !== 5'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err: err=%0b log=%0d busy=%0b required 1/0/0", cfg_err, ef_log, busy);
        end
        pulse(32'sd0, 32'sd999);
        checks++;
        if (st_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid: got %0b required 0", st_valid);
        end
        en = 1'b0;
        tick();
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_clear: got %0b required 0", cfg_err);
        end
        arm(3'd4, 4'd0);
        en = 1'b0;
        ef_min = 32'd0; ef_max = 32'd777; ef_valid = 1'b1;
        #1;
        checks++;
        if (ef_log !== 5'd0) begin
            errors++;
            $display("FAIL abort_log: got %0d required 0", ef_log);
        end
        tick();
        ef_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || st_valid !== 1'b0 || p2p === 32'd777 || ef_shift !== 3'd4) begin
            errors++;
            $display("FAIL abort: busy=%0b valid=%0b p2p=%0d shift=%0d required 0/0/not777/4", busy, st_valid, p2p, ef_shift);
        end
    endtask

    task automatic test_async_reset();
        arm(3'd5, 4'd2);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ef_log, ef_shift, p2p, st_valid, over, under, cfg_err, busy} !== '0) begin
            errors++;
            $display("FAIL async_reset: outputs=%h required 0", {ef_log, ef_shift, p2p, st_valid, over, under, cfg_err, busy});
        end
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

`ifdef EXTREMUM_CTRL_WATCHDOG_EN
    task automatic test_watchdog();
        arm(3'd2, 4'd0);
        for (int i = 0; i < 40 && !timeout; i++) tick();
        checks++;
        if (timeout !== 1'b1 || ef_log !== 5'd0 || ef_shift !== 3'd2) begin
            errors++;
            $display("FAIL watchdog: timeout=%0b log=%0d shift=%0d required 1/0/2", timeout, ef_log, ef_shift);
        end
        en = 1'b0;
        tick();
        tick();
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL watchdog_clear: got %0b required 0", timeout);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_discard_and_measure();
        test_shift_up();
        test_boundaries();
        test_range_flags();
        test_cfg_err_and_abort();
        test_async_reset();
`ifdef EXTREMUM_CTRL_WATCHDOG_EN
        test_watchdog();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
